pll_lock_sequencer: RTL and testbench
=====================================

// Module: pll_lock_sequencer
// PURPOSE
//  Controller on the far side of the PLL wrapper's rst/locked interface: drives the PLL reset,
//  consumes its asynchronous locked flag, and releases the core reset only after lock is stable.
//  Retries the PLL on lock timeout, re-sequences on loss of lock, reports status to the core.
//  Sits in the refclk (74.25 MHz) domain, upstream of every core-clock reset synchronizer.
// PARAMETERS
//  SYNC_STAGES         2      flops in pll_locked synchronizer (>=2)
//  PLL_RST_CYCLES      16     refclk cycles pll_rst is held high per attempt (>=1)
//  LOCK_STABLE_CYCLES  1024   consecutive synced-locked cycles required before release (>=1)
//  LOCK_TIMEOUT_CYCLES 74250  max cycles from PLL_RST exit to release before retry (1 ms)
//  MAX_RETRIES         3      timeouts tolerated before FAIL (1..15)
// PORTS
//  refclk        in   1  block clock (PLL reference clock)
//  rst           in   1  asynchronous, active-high reset
//  pll_locked    in   1  PLL locked flag, asynchronous to refclk
//  pll_rst       out  1  reset to PLL, active-high
//  core_reset    out  1  reset to core logic, active-high
//  ready         out  1  high only in RUN (== ~core_reset & ~fail)
//  lock_lost     out  1  one-cycle pulse on loss of lock while in RUN
//  lost_count    out  8  saturating count of lock_lost pulses
//  retry_count   out  4  timeouts since rst
//  fail          out  1  sticky: MAX_RETRIES timeouts reached
// BEHAVIOUR
//  Clock and reset: one clock, refclk; reset rst is asynchronous, active-high. All flops clear
//   asynchronously on rst.
//  Reset values: pll_rst=1, core_reset=1, ready=0, lock_lost=0, lost_count=0, retry_count=0,
//   fail=0, state=PLL_RST, all counters 0, synchronizer flops 0.
//  locked_s = pll_locked through SYNC_STAGES flops; FSM uses only locked_s.
//  FSM states (all outputs registered):
//   PLL_RST: pll_rst=1, core_reset=1. Count PLL_RST_CYCLES cycles -> WAIT_LOCK; clear tmo counter.
//   WAIT_LOCK: pll_rst=0. locked_s=1 -> STABLE (stable counter=1). tmo counter runs.
//   STABLE: locked_s=1 increments stable counter; reaching LOCK_STABLE_CYCLES -> RUN.
//    locked_s=0 -> WAIT_LOCK, stable counter cleared; tmo counter NOT cleared.
//   Timeout (WAIT_LOCK or STABLE): tmo counter reaches LOCK_TIMEOUT_CYCLES -> retry_count+1;
//    if new value == MAX_RETRIES -> FAIL, else -> PLL_RST. Timeout wins over same-cycle RUN entry.
//   RUN: core_reset=0, ready=1. locked_s=0 -> lock_lost=1 for exactly that cycle,
//    lost_count+1 (saturates 255), -> PLL_RST. retry_count not changed by loss of lock.
//   FAIL: terminal until rst. fail=1, pll_rst=0, core_reset=1, ready=0; pll_locked ignored.
//  Latency: pll_locked rising (held) in WAIT_LOCK -> core_reset falls exactly
//   SYNC_STAGES+LOCK_STABLE_CYCLES+1 refclk edges later. locked falling in RUN -> lock_lost and
//   core_reset rise SYNC_STAGES+1 edges later; pll_rst rises same edge.
//  Counter widths: $clog2(param+1); no wrap (each counter cleared on state entry).
//  rst mid-operation (any state, incl. RUN/FAIL): immediate return to reset values, full restart.
//  Glitch on pll_locked shorter than one refclk may be missed; no requirement to catch it.
// TESTING (PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=64, MAX_RETRIES=2)
//  1 rst release, pll_locked=1 from cycle 10 -> pll_rst high 4 cycles, core_reset falls 11 edges
//    after locked sampled high, ready=1, retry_count=0.
//  2 pll_locked held 0 -> pll_rst re-pulses once after 64 cycles (retry_count=1), after second
//    timeout fail=1, retry_count=2, pll_rst=0, core_reset stays 1 for 500 more cycles.
//  3 In RUN, drop pll_locked -> single-cycle lock_lost, lost_count=1, pll_rst 4 cycles,
//    relock -> ready again; repeat 300 times -> lost_count=255.
//  4 pll_locked toggles 5 high/1 low in STABLE -> never reaches RUN; timeout at 64 -> retry_count=1.
//  5 Assert rst for 1 cycle while in RUN and in FAIL -> all outputs to reset values same cycle,
//    sequence restarts as in test 1.
//  6 pll_locked rises so STABLE completes on the timeout cycle -> timeout wins: retry_count=1, PLL_RST.

Source files
------------

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer in the refclk domain: pulses the PLL reset, waits for a stable
// synchronized lock, releases the core reset, and retries or fails on lock timeout.
module pll_lock_sequencer #(
  parameter int unsigned SYNC_STAGES         = 2,
  parameter int unsigned PLL_RST_CYCLES      = 16,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 74250,
  parameter int unsigned MAX_RETRIES         = 3
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       core_reset,
  output logic       ready,
  output logic       lock_lost,
  output logic [7:0] lost_count,
  output logic [3:0] retry_count,
  output logic       fail
);

  // state     | meaning
  // PLL_RST   | PLL held in reset for PLL_RST_CYCLES, core in reset
  // WAIT_LOCK | PLL released, waiting for synchronized lock, timeout running
  // STABLE    | lock seen, counting consecutive locked cycles, timeout running
  // RUN       | core released; loss of lock re-sequences
  // FAIL      | retries exhausted, terminal until rst

  localparam int RST_W = $clog2(PLL_RST_CYCLES + 1);
  localparam int STB_W = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int TMO_W = $clog2(LOCK_TIMEOUT_CYCLES + 1);

  localparam logic [2:0] ST_PLL_RST   = 3'd0;
  localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
  localparam logic [2:0] ST_STABLE    = 3'd2;
  localparam logic [2:0] ST_RUN       = 3'd3;
  localparam logic [2:0] ST_FAIL      = 3'd4;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   locked_s;

  logic [2:0]       state, state_nxt;
  logic [RST_W-1:0] rst_cnt, rst_cnt_nxt;
  logic [STB_W-1:0] stable_cnt, stable_cnt_nxt;
  logic [TMO_W-1:0] tmo_cnt, tmo_cnt_nxt;
  logic [3:0]       retry_nxt;
  logic [7:0]       lost_nxt;
  logic             lock_lost_nxt;

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
  end

  assign locked_s = sync_q[SYNC_STAGES-1];

  // Timeout is evaluated before RUN entry so it wins when both land on the same cycle.
  always_comb begin
    state_nxt      = state;
    rst_cnt_nxt    = rst_cnt;
    stable_cnt_nxt = stable_cnt;
    tmo_cnt_nxt    = tmo_cnt;
    retry_nxt      = retry_count;
    lost_nxt       = lost_count;
    lock_lost_nxt  = 1'b0;
    case (state)
      ST_PLL_RST: begin
        if (rst_cnt == RST_W'(PLL_RST_CYCLES - 1)) begin
          state_nxt      = ST_WAIT_LOCK;
          tmo_cnt_nxt    = '0;
          stable_cnt_nxt = '0;
        end else begin
          rst_cnt_nxt = rst_cnt + RST_W'(1);
        end
      end
      ST_WAIT_LOCK, ST_STABLE: begin
        if (tmo_cnt == TMO_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
          retry_nxt = retry_count + 4'd1;
          if (retry_nxt == 4'(MAX_RETRIES)) begin
            state_nxt = ST_FAIL;
          end else begin
            state_nxt   = ST_PLL_RST;
            rst_cnt_nxt = '0;
          end
        end else begin
          tmo_cnt_nxt = tmo_cnt + TMO_W'(1);
          if (state == ST_WAIT_LOCK) begin
            if (locked_s) begin
              state_nxt      = ST_STABLE;
              stable_cnt_nxt = STB_W'(1);
            end
          end else if (!locked_s) begin
            state_nxt      = ST_WAIT_LOCK;
            stable_cnt_nxt = '0;
          end else if (stable_cnt == STB_W'(LOCK_STABLE_CYCLES)) begin
            state_nxt = ST_RUN;
          end else begin
            stable_cnt_nxt = stable_cnt + STB_W'(1);
          end
        end
      end
      ST_RUN: begin
        if (!locked_s) begin
          lock_lost_nxt = 1'b1;
          if (lost_count != 8'hFF) lost_nxt = lost_count + 8'd1;
          state_nxt   = ST_PLL_RST;
          rst_cnt_nxt = '0;
        end
      end
      ST_FAIL: begin
        state_nxt = ST_FAIL;
      end
      default: begin
        state_nxt   = ST_PLL_RST;
        rst_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state       <= ST_PLL_RST;
      rst_cnt     <= '0;
      stable_cnt  <= '0;
      tmo_cnt     <= '0;
      retry_count <= '0;
      lost_count  <= '0;
      lock_lost   <= 1'b0;
      pll_rst     <= 1'b1;
      core_reset  <= 1'b1;
      ready       <= 1'b0;
      fail        <= 1'b0;
    end else begin
      state       <= state_nxt;
      rst_cnt     <= rst_cnt_nxt;
      stable_cnt  <= stable_cnt_nxt;
      tmo_cnt     <= tmo_cnt_nxt;
      retry_count <= retry_nxt;
      lost_count  <= lost_nxt;
      lock_lost   <= lock_lost_nxt;
      pll_rst     <= (state_nxt == ST_PLL_RST);
      core_reset  <= (state_nxt != ST_RUN);
      ready       <= (state_nxt == ST_RUN);
      fail        <= (state_nxt == ST_FAIL);
    end
  end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with small timing parameters; expectations are
// queued as stimulus is applied and popped when the corresponding DUT output is observed.
module tb_pll_lock_sequencer;

  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       pll_rst, core_reset, ready, lock_lost, fail;
  logic [7:0] lost_count;
  logic [3:0] retry_count;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;
  exp_t sb_q[$];

  pll_lock_sequencer #(
    .SYNC_STAGES(2),
    .PLL_RST_CYCLES(4),
    .LOCK_STABLE_CYCLES(8),
    .LOCK_TIMEOUT_CYCLES(64),
    .MAX_RETRIES(2)
  ) dut (
    .refclk(refclk),
    .rst(rst),
    .pll_locked(pll_locked),
    .pll_rst(pll_rst),
    .core_reset(core_reset),
    .ready(ready),
    .lock_lost(lock_lost),
    .lost_count(lost_count),
    .retry_count(retry_count),
    .fail(fail)
  );

  always #5 refclk = ~refclk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge refclk);
      #1;
    end
  endtask

  task automatic push(input string tag, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    n_tests++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed %0d required an expectation", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.exp) else begin
        n_fail++;
        $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.exp);
      end
    end
  endtask

  function automatic logic cond(input int which);
    case (which)
      0:       return ready;
      1:       return pll_rst;
      2:       return lock_lost;
      3:       return fail;
      default: return pll_rst | ready;
    endcase
  endfunction

  // Counts edges until the selected output goes high; a missed bound returns limit.
  task automatic edges_until(input int which, input int limit, output int n);
    n = 0;
    while (!cond(which) && n < limit) begin
      tick(1);
      n++;
    end
  endtask

  task automatic do_reset(input logic locked);
    rst = 1'b1;
    pll_locked = locked;
    tick(2);
    rst = 1'b0;
  endtask

  initial begin
    int n;
    int bad;

    // reset values
    tick(2);
    push("rst_pll_rst", 1);     check(pll_rst);
    push("rst_core_reset", 1);  check(core_reset);
    push("rst_ready", 0);       check(ready);
    push("rst_lock_lost", 0);   check(lock_lost);
    push("rst_lost_count", 0);  check(lost_count);
    push("rst_retry_count", 0); check(retry_count);
    push("rst_fail", 0);        check(fail);

    // 1: normal bring-up, lock from cycle 10
    rst = 1'b0;
    tick(3);
    push("t1_pll_rst_held", 1); check(pll_rst);
    tick(1);
    push("t1_pll_rst_off", 0);  check(pll_rst);
    tick(6);
    pll_locked = 1'b1;
    push("t1_lock_latency", 11);
    edges_until(0, 100, n);
    check(n);
    push("t1_core_reset", 0);   check(core_reset);
    push("t1_ready", 1);        check(ready);
    push("t1_retry", 0);        check(retry_count);

    // 3: loss of lock in RUN
    pll_locked = 1'b0;
    push("t3_lost_latency", 3);
    edges_until(2, 20, n);
    check(n);
    push("t3_core_reset", 1);   check(core_reset);
    push("t3_pll_rst_rise", 1); check(pll_rst);
    push("t3_ready", 0);        check(ready);
    push("t3_lost_count1", 1);  check(lost_count);
    tick(1);
    push("t3_lost_pulse", 0);   check(lock_lost);
    tick(2);
    push("t3_pll_rst_held", 1); check(pll_rst);
    tick(1);
    push("t3_pll_rst_off", 0);  check(pll_rst);
    pll_locked = 1'b1;
    push("t3_relock", 11);
    edges_until(0, 100, n);
    check(n);
    bad = 0;
    for (int i = 0; i < 299; i++) begin
      pll_locked = 1'b0;
      edges_until(2, 20, n);
      if (n == 20) bad++;
      pll_locked = 1'b1;
      edges_until(0, 60, n);
      if (n == 60) bad++;
    end
    push("t3_loop_stalls", 0);  check(bad);
    push("t3_lost_sat", 255);   check(lost_count);
    push("t3_retry", 0);        check(retry_count);

    // 5a: rst pulse while in RUN
    rst = 1'b1;
    #1;
    push("t5a_pll_rst", 1);     check(pll_rst);
    push("t5a_core_reset", 1);  check(core_reset);
    push("t5a_ready", 0);       check(ready);
    push("t5a_lost_count", 0);  check(lost_count);
    tick(1);
    rst = 1'b0;
    tick(3);
    push("t5a_pll_rst_held", 1); check(pll_rst);
    tick(1);
    push("t5a_pll_rst_off", 0); check(pll_rst);
    push("t5a_restart", 9);
    edges_until(0, 100, n);
    check(n);

    // 2: no lock -> retry then FAIL
    do_reset(1'b0);
    tick(4);
    push("t2_pll_rst_off", 0);  check(pll_rst);
    push("t2_timeout1", 64);
    edges_until(1, 200, n);
    check(n);
    push("t2_retry1", 1);       check(retry_count);
    tick(3);
    push("t2_repulse_held", 1); check(pll_rst);
    tick(1);
    push("t2_repulse_off", 0);  check(pll_rst);
    push("t2_timeout2", 64);
    edges_until(3, 200, n);
    check(n);
    push("t2_retry2", 2);       check(retry_count);
    push("t2_fail_pll_rst", 0); check(pll_rst);
    push("t2_fail_core", 1);    check(core_reset);
    pll_locked = 1'b1;
    bad = 0;
    for (int i = 0; i < 500; i++) begin
      tick(1);
      if (core_reset !== 1'b1 || pll_rst !== 1'b0 || ready !== 1'b0 || fail !== 1'b1) bad++;
    end
    push("t2_fail_sticky", 0);  check(bad);

    // 5b: rst pulse while in FAIL, restart with lock held
    rst = 1'b1;
    #1;
    push("t5b_fail", 0);        check(fail);
    push("t5b_retry", 0);       check(retry_count);
    push("t5b_pll_rst", 1);     check(pll_rst);
    tick(1);
    rst = 1'b0;
    push("t5b_restart", 13);
    edges_until(0, 100, n);
    check(n);

    // 4: 5 high / 1 low in STABLE -> timeout, not RUN
    do_reset(1'b0);
    tick(4);
    n = 0;
    while (!pll_rst && !ready && n < 200) begin
      pll_locked = ((n % 6) != 5);
      tick(1);
      n++;
    end
    push("t4_timeout", 64);     check(n);
    push("t4_no_run", 0);       check(ready);
    push("t4_retry", 1);        check(retry_count);

    // 6a: RUN entry one cycle before the timeout
    do_reset(1'b0);
    tick(56);
    pll_locked = 1'b1;
    push("t6a_run", 11);
    edges_until(0, 40, n);
    check(n);
    push("t6a_retry", 0);       check(retry_count);

    // 6b: RUN entry on the timeout cycle -> timeout wins
    do_reset(1'b0);
    tick(57);
    pll_locked = 1'b1;
    push("t6b_edge", 11);
    edges_until(4, 40, n);
    check(n);
    push("t6b_no_run", 0);      check(ready);
    push("t6b_pll_rst", 1);     check(pll_rst);
    push("t6b_retry", 1);       check(retry_count);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
